// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SUB_W = 4;

endpackage

// File: rtl/fsub1.sv
// One-bit full subtractor cell: difference and borrow-out from a - b - bi.
module fsub1 (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub4.sv
// Bit-serial subtractor: one bit per clock, LSB first, with unsigned borrow and signed overflow flags.
// Handshake: start is sampled only in IDLE; busy covers RUN and DONE; done pulses for the one DONE cycle.
module serial_sub4
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             bi;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bo;

    fsub1 u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (bi),
        .d  (d),
        .bo (bo)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // The minuend register doubles as the result register: each consumed
    // operand bit is replaced by the difference bit entering at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            bi     <= 1'b0;
            cnt    <= '0;
            out    <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= in1;
                        b_sr  <= in2;
                        bi    <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= {d, a_sr[WIDTH-1:1]};
                    b_sr <= b_sr >> 1;
                    bi   <= bo;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // On this edge a_sr[0]/b_sr[0] are the original operand MSBs.
                        out    <= {d, a_sr[WIDTH-1:1]};
                        borrow <= bo;
                        ovf    <= (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub4.sv
// Directed bench for serial_sub4 (WIDTH=4): vector table plus timing, ignore, back-to-back and reset sequences.
module tb_serial_sub4;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         borrow;
    logic         ovf;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [W-1:0] in1;
        logic [W-1:0] in2;
        logic [W-1:0] out;
        logic         borrow;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    serial_sub4 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in1    (in1),
        .in2    (in2),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .borrow (borrow),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation, checking accept, latency, result, done width and hold.
    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e_out, input logic e_borrow, input logic e_ovf);
        int n;
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, " busy_after_accept"}, busy, 1);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, W);
        check({name, " out"}, out, e_out);
        check({name, " borrow"}, borrow, e_borrow);
        check({name, " ovf"}, ovf, e_ovf);
        tick();
        check({name, " done_one_cycle"}, done, 0);
        check({name, " busy_cleared"}, busy, 0);
        check({name, " out_held"}, out, e_out);
    endtask

    initial begin
        int n;
        int dones;
        vecs[0] = '{4'd12, 4'd15, 4'd13, 1'b1, 1'b0};
        vecs[1] = '{4'd12, 4'd2,  4'd10, 1'b0, 1'b0};
        vecs[2] = '{4'd15, 4'd1,  4'd14, 1'b0, 1'b0};
        vecs[3] = '{4'd8,  4'd3,  4'd5,  1'b0, 1'b1};
        vecs[4] = '{4'd6,  4'd7,  4'd15, 1'b1, 1'b0};
        vecs[5] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
        vecs[6] = '{4'd7,  4'd8,  4'd15, 1'b1, 1'b1};
        vecs[7] = '{4'd0,  4'd1,  4'd15, 1'b1, 1'b0};
        vecs[8] = '{4'd3,  4'd12, 4'd7,  1'b1, 1'b0};
        vecs[9] = '{4'd4,  4'd11, 4'd9,  1'b1, 1'b1};

        // Reset state
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset out", out, 0);
        check("reset borrow", borrow, 0);
        check("reset ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].in1, vecs[i].in2,
                  vecs[i].out, vecs[i].borrow, vecs[i].ovf);
        end

        // Edge-by-edge timing: done only between edges 4 and 5
        @(negedge clk);
        in1 = 4'd12; in2 = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        check("timing busy e0", busy, 1);
        check("timing done e0", done, 0);
        for (int e = 1; e <= 3; e++) begin
            tick();
            check($sformatf("timing done e%0d", e), done, 0);
            check($sformatf("timing busy e%0d", e), busy, 1);
        end
        tick();
        check("timing done e4", done, 1);
        check("timing busy e4", busy, 1);
        tick();
        check("timing done e5", done, 0);
        check("timing busy e5", busy, 0);

        // start and new operands during RUN are ignored
        @(negedge clk);
        in1 = 4'd12; in2 = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        tick();
        in1 = 4'd0; in2 = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                dones++;
                check("ignore out", out, 13);
                check("ignore borrow", borrow, 1);
            end
            tick();
        end
        check("ignore done count", dones, 1);
        check("ignore idle", busy, 0);

        // Back-to-back: start held high gives one op per W+2 cycles
        @(negedge clk);
        in1 = 4'd6; in2 = 4'd7; start = 1'b1;
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("b2b first done", done, 1);
        n = 0;
        tick();
        n++;
        while (!done && n < 20) begin tick(); n++; end
        check("b2b period", n, W + 2);
        check("b2b out", out, 15);
        start = 1'b0;
        repeat (3) tick();
        check("b2b idle", busy, 0);

        // Reset mid-RUN aborts at once with no done pulse
        @(negedge clk);
        in1 = 4'd8; in2 = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort out", out, 0);
        check("abort borrow", borrow, 0);
        check("abort ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) dones++;
        end
        check("abort no done", dones, 0);
        do_op("post_reset", 4'd6, 4'd7, 4'd15, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_sub4.md
SERIAL_SUB4 -- requirements
Module: serial_sub4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port in1, input, WIDTH bits: minuend, unsigned or two's complement.
REQ-006 The block SHALL have port in2, input, WIDTH bits: subtrahend, same encoding as in1.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the result is valid.
REQ-009 The block SHALL have port out, output, WIDTH bits: difference in1 - in2 modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow, output, 1 bit: unsigned borrow, high when in1 < in2.
REQ-011 The block SHALL have port ovf, output, 1 bit: signed overflow of the two's-complement difference.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL leave reset in IDLE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL capture in1 and in2 into shift registers, clear the internal borrow, clear the bit counter, set busy=1 and enter RUN.
REQ-014 In RUN, each edge SHALL process one bit, LSB first: d = a^b^bi; bo = (~a&b) | (~(a^b)&bi).
REQ-015 In RUN, each edge SHALL shift d into the result register and bo into the internal borrow, and SHALL increment the counter.
REQ-016 RUN SHALL last exactly WIDTH edges; the edge that processes bit WIDTH-1 SHALL load out, borrow and ovf and enter DONE.
REQ-017 ovf SHALL equal (a_msb != b_msb) && (d_msb != a_msb), using the captured operand MSBs.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, busy SHALL be 1, and the next edge SHALL return the FSM to IDLE with busy=0.
REQ-019 Latency: with start accepted at edge 0, done SHALL be high between edge WIDTH and edge WIDTH+1, i.e. WIDTH+1 cycles from accept to IDLE.
REQ-020 start in RUN or DONE SHALL be ignored; it SHALL NOT be queued, and in1/in2 changes during RUN SHALL NOT affect the result.
REQ-021 out, borrow and ovf SHALL hold their last values from DONE until the next operation loads them.
REQ-022 Back-to-back: start held high SHALL be accepted again at the first edge in IDLE, giving one operation per WIDTH+2 cycles.
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap inside an operation.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE and busy=0, done=0, out=0, borrow=0, ovf=0, and clear the counter and shift registers, with no clock required.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse.
REQ-026 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge.

Structure
REQ-027 Package sub_pkg SHALL hold the state enumeration (IDLE/RUN/DONE) and the default width constant SUB_W=4.
REQ-028 The one-bit cell SHALL be a combinational sub-module fsub1 (inputs a, b, bi; outputs d, bo), instantiated once in serial_sub4.

Verification
REQ-029 in1=12, in2=15, start pulse -> after 4 RUN cycles done=1, out=13, borrow=1, ovf=0.
REQ-030 in1=12, in2=2 -> out=10, borrow=0, ovf=0; in1=15, in2=1 -> out=14, borrow=0, ovf=0.
REQ-031 in1=8, in2=3 -> out=5, borrow=0, ovf=1 (-8-3); in1=6, in2=7 -> out=15, borrow=1, ovf=0.
REQ-032 Timing check: start accepted at edge 0 -> busy=1 after edge 0, done high only between edges 4 and 5, busy=0 after edge 5.
REQ-033 Ignore check: start pulse with new operands during RUN -> no effect, result matches the original operands, exactly one done pulse.
REQ-034 Reset check: rst_n low mid-RUN -> out/borrow/ovf/busy/done=0 at once, no done pulse; a fresh op 6-7 afterwards -> out=15, borrow=1.
